req_pending_latch: RTL and testbench

Upstream stage of the 16-input priority encoder.
- Synchronises 16 asynchronous request lines and captures each rising edge into a sticky pending register.
- Presents the masked pending vector as the encoder's 16-bit input.
- Pending bits stay set until the consumer acknowledges the index it serviced.
- Records overruns: a new edge arriving on a line that is still pending.

---
 rtl/req_pkg.sv | 7 +
 rtl/sync_bus.sv | 35 +++
 rtl/req_pending_latch.sv | 73 +++++++
 tb/tb_req_pending_latch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/req_pkg.sv
// Shared widths and codes for the 16-input priority encoder datapath.
// Constants only; no logic, no latency, no flow control.
package req_pkg;
    localparam int         REQ_WIDTH   = 16;
    localparam int         REQ_IDX_W   = 4;
    localparam logic [7:0] NO_REQ_CODE = 8'hF0;
endpackage

// File: rtl/sync_bus.sv
// Multi-bit flop-chain synchroniser; latency SYNC_STAGES edges.
// No backpressure: each bit is an independent level, sampled every cycle.
module sync_bus #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    always_comb begin
        stage_d[0] = async_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/req_pending_latch.sv
// Sticky rising-edge request capture feeding the priority encoder; pending set SYNC_STAGES edges after req_in sampled high.
// No backpressure: bits hold until acked, and a repeat edge on a held bit is coalesced and flagged in overrun.
module req_pending_latch
    import req_pkg::*;
#(
    parameter int WIDTH       = REQ_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req_in,
    input  logic                     mask_wr,
    input  logic [WIDTH-1:0]         mask_data,
    input  logic                     ack_valid,
    input  logic [$clog2(WIDTH)-1:0] ack_idx,
    input  logic                     overrun_clr,
    output logic [WIDTH-1:0]         pend_out,
    output logic                     pend_valid,
    output logic [WIDTH-1:0]         pending_raw,
    output logic [WIDTH-1:0]         overrun
);

    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] ack_vec;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ovr_q,  ovr_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    sync_bus #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(req_in),
        .sync_out(sync_w)
    );

    always_comb begin
        ack_vec = '0;
        if (ack_valid) begin
            ack_vec[ack_idx] = 1'b1;
        end
        rise   = sync_w & ~hist_q;
        hist_d = sync_w;
        // A rise wins over an ack on the same bit: it is a fresh event.
        pend_d = rise | (pend_q & ~ack_vec);
        ovr_d  = (ovr_q & {WIDTH{~overrun_clr}}) | (rise & pend_q & ~ack_vec);
        mask_d = mask_wr ? mask_data : mask_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
            mask_q <= '1;
        end else begin
            hist_q <= hist_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            mask_q <= mask_d;
        end
    end

    assign pend_out    = pend_q & mask_q;
    assign pend_valid  = |pend_out;
    assign pending_raw = pend_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_req_pending_latch.sv
// Randomised and directed bench for req_pending_latch against an edge-history reference model.
module tb_req_pending_latch;
    import req_pkg::*;

    localparam int W = REQ_WIDTH;
    localparam int S = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [W-1:0]         req_in;
    logic                 mask_wr;
    logic [W-1:0]         mask_data;
    logic                 ack_valid;
    logic [REQ_IDX_W-1:0] ack_idx;
    logic                 overrun_clr;
    logic [W-1:0]         pend_out;
    logic                 pend_valid;
    logic [W-1:0]         pending_raw;
    logic [W-1:0]         overrun;

    int errors = 0;
    int checks = 0;

    // Reference state: past req_in samples (index 0 = most recent edge), pending, overrun, mask.
    logic [W-1:0] smp [$];
    logic [W-1:0] m_pend, m_ovr, m_mask;

    always #5 clk = ~clk;

    req_pending_latch #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .ack_valid  (ack_valid),
        .ack_idx    (ack_idx),
        .overrun_clr(overrun_clr),
        .pend_out   (pend_out),
        .pend_valid (pend_valid),
        .pending_raw(pending_raw),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        smp = {};
        for (int i = 0; i <= S; i++) smp.push_back('0);
        m_pend = '0;
        m_ovr  = '0;
        m_mask = '1;
    endtask

    // A line's synchronised edge is seen S edges after it was sampled high
    // following a low sample.
    task automatic model_edge();
        logic [W-1:0] rise, ackv, dropped;
        rise = smp[S-1] & ~smp[S];
        ackv = '0;
        if (ack_valid) ackv[ack_idx] = 1'b1;
        m_ovr  = (overrun_clr ? '0 : m_ovr) | (rise & m_pend & ~ackv);
        m_pend = (m_pend & ~ackv) | rise;
        if (mask_wr) m_mask = mask_data;
        smp.push_front(req_in);
        dropped = smp.pop_back();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pend_out"},    32'(pend_out),    32'(m_pend & m_mask));
        chk({tag, ".pend_valid"},  32'(pend_valid),  32'(|(m_pend & m_mask)));
        chk({tag, ".pending_raw"}, 32'(pending_raw), 32'(m_pend));
        chk({tag, ".overrun"},     32'(overrun),     32'(m_ovr));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        mask_wr     = 1'b0;
        ack_valid   = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic do_ack(input int idx);
        ack_valid = 1'b1;
        ack_idx   = REQ_IDX_W'(idx);
        step("ack");
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, ".pend_out"},    32'(pend_out),    32'h0);
        chk({tag, ".pend_valid"},  32'(pend_valid),  32'h0);
        chk({tag, ".pending_raw"}, 32'(pending_raw), 32'h0);
        chk({tag, ".overrun"},     32'(overrun),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_in = '0; mask_wr = 1'b0; mask_data = '0;
        ack_valid = 1'b0; ack_idx = '0; overrun_clr = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step("idle");
        chk("idle_pend_out", 32'(pend_out), 32'h0);

        // Two-line pulse, pending after edge k+2, then acked one by one.
        req_in = 16'h8001; step("pulse");
        req_in = '0;       step("pulse");
        step("pulse");
        chk("pulse_pend_out", 32'(pend_out), 32'h8001);
        chk("pulse_valid",    32'(pend_valid), 32'h1);
        do_ack(15);
        chk("ack15_pend_out", 32'(pend_out), 32'h0001);
        do_ack(0);
        chk("ack0_pend_out", 32'(pend_out), 32'h0);
        chk("ack0_valid",    32'(pend_valid), 32'h0);
        do_ack(7);

        // Overrun on line 5, then clear while pending is retained.
        repeat (2) begin
            req_in = 16'h0020; step("ovr");
            req_in = '0;       step("ovr");
            step("ovr");
        end
        chk("ovr_overrun", 32'(overrun),     32'h0020);
        chk("ovr_raw",     32'(pending_raw), 32'h0020);
        overrun_clr = 1'b1; step("ovr_clr");
        chk("ovr_clr_overrun", 32'(overrun),     32'h0);
        chk("ovr_clr_raw",     32'(pending_raw), 32'h0020);
        do_ack(5);

        // Line 3 rise coincides with its own ack while already pending.
        req_in = 16'h0008; step("coin");
        req_in = '0;       step("coin");
        step("coin");
        req_in = 16'h0008; step("coin");
        req_in = '0;       step("coin");
        ack_valid = 1'b1; ack_idx = 4'd3; step("coin");
        chk("coin_raw3", 32'(pending_raw[3]), 32'h1);
        chk("coin_ovr3", 32'(overrun[3]),     32'h0);
        do_ack(3);

        // Masking hides but keeps pending bits; unmask re-exposes them.
        mask_wr = 1'b1; mask_data = 16'hFF00; step("mask");
        req_in = 16'h0101; step("mask");
        req_in = '0;       step("mask");
        step("mask");
        chk("mask_pend_out", 32'(pend_out),    32'h0100);
        chk("mask_raw",      32'(pending_raw), 32'h0101);
        mask_wr = 1'b1; mask_data = 16'hFFFF; step("unmask");
        chk("unmask_pend_out", 32'(pend_out), 32'h0101);
        do_ack(0);
        do_ack(8);

        // Level held through reset gives exactly one rise per line.
        req_in = 16'hFFFF;
        async_reset("rst_hold");
        step("hold"); step("hold");
        chk("hold_raw_before", 32'(pending_raw), 32'h0);
        step("hold");
        chk("hold_raw", 32'(pending_raw), 32'hFFFF);
        repeat (5) step("hold");
        chk("hold_overrun", 32'(overrun), 32'h0);
        async_reset("rst_mid");
        req_in = '0;
        repeat (3) step("post_rst");

        // Randomised traffic, with occasional asynchronous reset.
        for (int n = 0; n < 600; n++) begin
            req_in = req_in ^ W'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) begin
                ack_valid = 1'b1;
                ack_idx   = REQ_IDX_W'($urandom_range(0, W - 1));
            end
            if ($urandom_range(0, 19) == 0) begin
                mask_wr   = 1'b1;
                mask_data = W'($urandom);
            end
            if ($urandom_range(0, 24) == 0) overrun_clr = 1'b1;
            step("rand");
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
